mem_port_arbiter: RTL

Sequential arbiter that shares one single-port synchronous memory between the pipeline's instruction-fetch port and its data (MEM-stage) port. It serializes accesses, returns read data with a one-cycle acknowledge pulse, and bounds fetch starvation. It sits between the `arm` core and a unified memory, replacing the separate instruction and data memories in a unified-memory build.

---
 rtl/arm_mem_pkg.sv | 23 ++
 rtl/mem_port_arbiter_if.sv | 39 +++
 rtl/mem_arb_prio.sv | 44 ++++
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 4 files changed

// File: rtl/arm_mem_pkg.sv
// Shared types and default parameters for the unified-memory port arbiter.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package arm_mem_pkg;

  localparam int DEF_AW         = 32;
  localparam int DEF_DW         = 32;
  localparam int DEF_MEM_LAT    = 1;
  localparam int DEF_STARVE_MAX = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch port, data port and memory port seen by the arbiter.
// Latency: n/a (wiring only).
// Backpressure: requesters hold req until their one-cycle ack.
interface mem_port_arbiter_if #(
  parameter int AW = arm_mem_pkg::DEF_AW,
  parameter int DW = arm_mem_pkg::DEF_DW
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ack;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;

  // Arbiter side.
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_rdata, i_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  // Core + memory side.
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_rdata, i_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arb_prio.sv
// Winner selection between fetch and data with a bounded fetch-starvation counter.
// Latency: winner is combinational; starve count updates on the grant edge.
// Backpressure: none; only sampled while the arbiter is idle.
module mem_arb_prio #(
  parameter int STARVE_MAX = arm_mem_pkg::DEF_STARVE_MAX
) (
  input  logic clk,
  input  logic reset,
  input  logic idle_i,
  input  logic i_req_i,
  input  logic d_req_i,
  output logic fetch_win_o
);
  localparam int SCW = $clog2(STARVE_MAX + 1);

  logic [SCW-1:0] starve_cnt_q, starve_cnt_d;

  // Data wins by default; fetch wins when alone or once data has starved it long enough.
  always_comb begin
    fetch_win_o = !d_req_i || (i_req_i && (starve_cnt_q >= SCW'(STARVE_MAX)));
  end

  // Count data grants taken while fetch waits; any fetch grant or idle without fetch clears it.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (idle_i) begin
      if (!i_req_i || fetch_win_o) begin
        starve_cnt_d = '0;
      end else if (starve_cnt_q != SCW'(STARVE_MAX)) begin
        starve_cnt_d = starve_cnt_q + SCW'(1);
      end
    end
  end

  // Starve counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between the fetch and data ports.
// Latency: request seen in IDLE -> ack 2+MEM_LAT cycles later; one access per 3+MEM_LAT cycles.
// Backpressure: requesters hold req until ack; the losing port waits for the next IDLE.
module mem_port_arbiter
  import arm_mem_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);
  localparam int WCW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  arb_state_e     state_q, state_d;
  owner_e         owner_q;
  logic           we_q;
  logic [AW-1:0]  addr_q;
  logic [DW-1:0]  wdata_q;
  logic           mem_en_q;
  logic           mem_we_q;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic [DW-1:0]  i_rdata_q;
  logic [DW-1:0]  d_rdata_q;

  logic idle;
  logic grant;
  logic fetch_win;
  logic capture;

  assign idle    = (state_q == IDLE);
  assign grant   = idle && (bus.i_req || bus.d_req);
  assign capture = (state_q == WAIT) && (wait_cnt_q == '0) && !we_q;

  mem_arb_prio #(
    .STARVE_MAX(STARVE_MAX)
  ) u_prio (
    .clk        (clk),
    .reset      (reset),
    .idle_i     (idle),
    .i_req_i    (bus.i_req),
    .d_req_i    (bus.d_req),
    .fetch_win_o(fetch_win)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: single-cycle issue, wait out the memory latency, one response cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.i_req || bus.d_req) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (wait_cnt_q == '0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: acks decode registered state only; memory strobes come from flops.
  always_comb begin
    bus.i_ack     = (state_q == RESP) && (owner_q == OWN_I);
    bus.d_ack     = (state_q == RESP) && (owner_q == OWN_D);
    bus.busy      = (state_q != IDLE);
    bus.mem_en    = mem_en_q;
    bus.mem_we    = mem_we_q;
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
    bus.i_rdata   = i_rdata_q;
    bus.d_rdata   = d_rdata_q;
  end

  // Latency counter: loaded during ISSUE, counts down through WAIT.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == ISSUE) begin
      wait_cnt_d = WCW'(MEM_LAT - 1);
    end else if ((state_q == WAIT) && (wait_cnt_q != '0)) begin
      wait_cnt_d = wait_cnt_q - WCW'(1);
    end
  end

  // Latency counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Latch the winning request at grant; the strobes are high only for the ISSUE cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q  <= OWN_I;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
    end else begin
      mem_en_q <= grant;
      mem_we_q <= grant && !fetch_win && bus.d_we;
      if (grant) begin
        owner_q <= fetch_win ? OWN_I : OWN_D;
        we_q    <= !fetch_win && bus.d_we;
        addr_q  <= fetch_win ? bus.i_addr : bus.d_addr;
        if (!fetch_win) begin
          wdata_q <= bus.d_wdata;
        end
      end
    end
  end

  // Capture read data on the last WAIT cycle into the owner's register; writes leave both alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else if (capture) begin
      if (owner_q == OWN_I) begin
        i_rdata_q <= bus.mem_rdata;
      end else begin
        d_rdata_q <= bus.mem_rdata;
      end
    end
  end

endmodule
